// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit: instruction field layout, opcode
// constants, FSM encodings and small decode helpers.
package alu_issue_unit_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NREGS = 16;
   localparam int INSTR_W   = 16;
   localparam int REG_IDX_W = 4;
   localparam int IMM_W     = 8;

   localparam logic [3:0] OPC_RTYPE = 4'b0000;
   localparam logic [3:0] OPX_CMP   = 4'b1011;
   localparam logic [3:0] OPC_CMPI  = 4'b1011;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_READ = 2'b01;
   localparam logic [1:0] ST_EXEC = 2'b10;
   localparam logic [1:0] ST_WB   = 2'b11;

   // Bit layout of a 16-bit instruction; opext/rsrc double as the 8-bit immediate.
   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] rdest;
      logic [3:0] opext;
      logic [3:0] rsrc;
   } instrFields_t;

   function automatic logic isRType(input instrFields_t instr);
      return instr.opcode == OPC_RTYPE;
   endfunction

   // Compares produce a result for the handshake but must never write back.
   function automatic logic isCompare(input instrFields_t instr);
      return (isRType(instr) && (instr.opext == OPX_CMP)) || (instr.opcode == OPC_CMPI);
   endfunction

   function automatic logic [IMM_W-1:0] getImm(input instrFields_t instr);
      return {instr.opext, instr.rsrc};
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue unit: NREGS x WIDTH, two asynchronous read
// ports, one synchronous write port, synchronous clear on reset.
module alu_regfile #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddrA_i,
   output logic [WIDTH-1:0] rdataA_o,
   input  logic [AW-1:0]    raddrB_i,
   output logic [WIDTH-1:0] rdataB_o
);

   logic [WIDTH-1:0] mem_q [NREGS];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdataA_o = mem_q[raddrA_i];
   assign rdataB_o = mem_q[raddrB_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue side of the ALU interface: accepts one instruction at a time, fetches
// operands, presents them to an external combinational ALU and writes the result back.
module alu_issue_unit
   import alu_issue_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREGS = DEF_NREGS
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [INSTR_W-1:0]   instrIn_i,
   input  logic                 instrValid_i,
   output logic                 instrReady_o,
   input  logic                 wrEn_i,
   input  logic [REG_IDX_W-1:0] wrAddr_i,
   input  logic [WIDTH-1:0]     wrData_i,
   output logic [WIDTH-1:0]     ain_o,
   output logic [WIDTH-1:0]     bin_o,
   output logic [INSTR_W-1:0]   instruction_o,
   input  logic [WIDTH-1:0]     aluOut_i,
   output logic                 resultValid_o,
   output logic [WIDTH-1:0]     result_o,
   output logic [REG_IDX_W-1:0] resultAddr_o
);

   logic [1:0]           state_q, state_d;
   instrFields_t         instrLat_q;
   logic [WIDTH-1:0]     ain_q, bin_q, result_q;
   logic [INSTR_W-1:0]   instruction_q;
   logic [REG_IDX_W-1:0] resultAddr_q;

   logic                 inIdle, inRead, inExec, inWb;
   logic                 accept;
   logic                 rfWe;
   logic [REG_IDX_W-1:0] rfWAddr;
   logic [WIDTH-1:0]     rfWData;
   logic [WIDTH-1:0]     rfRdA, rfRdB;
   logic [WIDTH-1:0]     immExt;
   logic [WIDTH-1:0]     operandB;

   assign inIdle = (state_q == ST_IDLE);
   assign inRead = (state_q == ST_READ);
   assign inExec = (state_q == ST_EXEC);
   assign inWb   = (state_q == ST_WB);
   assign accept = instrValid_i && inIdle;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_READ;
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The write port serves preloads while idle and writeback in WB; the two
   // states are exclusive so no arbitration is needed.
   always_comb begin
      rfWe    = 1'b0;
      rfWAddr = wrAddr_i;
      rfWData = wrData_i;
      if (inIdle && wrEn_i) begin
         rfWe = 1'b1;
      end else if (inWb && !isCompare(instrFields_t'(instruction_q))) begin
         rfWe    = 1'b1;
         rfWAddr = resultAddr_q;
         rfWData = result_q;
      end
   end

   alu_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .AW    (REG_IDX_W)
   ) uRegfile (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .we_i     (rfWe),
      .waddr_i  (rfWAddr),
      .wdata_i  (rfWData),
      .raddrA_i (instrLat_q.rdest),
      .rdataA_o (rfRdA),
      .raddrB_i (instrLat_q.rsrc),
      .rdataB_o (rfRdB)
   );

   assign immExt   = {{(WIDTH-IMM_W){getImm(instrLat_q)[IMM_W-1]}}, getImm(instrLat_q)};
   assign operandB = isRType(instrLat_q) ? rfRdB : immExt;

   // Operands are only loaded in READ so the ALU sees stable inputs through EXEC and WB.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         instrLat_q    <= '0;
         ain_q         <= '0;
         bin_q         <= '0;
         instruction_q <= '0;
         result_q      <= '0;
         resultAddr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            instrLat_q <= instrFields_t'(instrIn_i);
         end
         if (inRead) begin
            ain_q         <= rfRdA;
            bin_q         <= operandB;
            instruction_q <= instrLat_q;
         end
         if (inExec) begin
            result_q     <= aluOut_i;
            resultAddr_q <= instrLat_q.rdest;
         end
      end
   end

   assign instrReady_o  = inIdle;
   assign resultValid_o = inWb;
   assign ain_o         = ain_q;
   assign bin_o         = bin_q;
   assign instruction_o = instruction_q;
   assign result_o      = result_q;
   assign resultAddr_o  = resultAddr_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit with a small behavioural ALU; results are predicted
// from a shadow register file and checked through a scoreboard queue.
module tb_alu_issue_unit;
   import alu_issue_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instrIn;
   logic        instrValid;
   logic        instrReady;
   logic        wrEn;
   logic [3:0]  wrAddr;
   logic [15:0] wrData;
   logic [15:0] ain, bin, instruction, aluOut, result;
   logic        resultValid;
   logic [3:0]  resultAddr;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  addr;
   } exp_t;

   exp_t        sbQ[$];
   logic [15:0] rfModel [16];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   alu_issue_unit dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .instrIn_i     (instrIn),
      .instrValid_i  (instrValid),
      .instrReady_o  (instrReady),
      .wrEn_i        (wrEn),
      .wrAddr_i      (wrAddr),
      .wrData_i      (wrData),
      .ain_o         (ain),
      .bin_o         (bin),
      .instruction_o (instruction),
      .aluOut_i      (aluOut),
      .resultValid_o (resultValid),
      .result_o      (result),
      .resultAddr_o  (resultAddr)
   );

   // Behavioural ALU standing in for the real one at integration level.
   function automatic logic [15:0] aluModel(input logic [15:0] ins, input logic [15:0] a,
                                            input logic [15:0] b);
      logic [15:0] r;
      r = a + b;
      if (ins[15:12] == 4'h0) begin
         case (ins[7:4])
            4'h5:    r = a + b;
            4'h9:    r = a - b;
            4'h1:    r = a & b;
            4'h2:    r = a | b;
            4'h3:    r = a ^ b;
            4'hB:    r = a - b;
            default: r = b;
         endcase
      end else begin
         case (ins[15:12])
            4'h9:    r = a - b;
            4'hB:    r = a - b;
            4'hD:    r = b;
            default: r = a + b;
         endcase
      end
      return r;
   endfunction

   always_comb aluOut = aluModel(instruction, ain, bin);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard drain: every ResultValid pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (!reset && resultValid) begin
         if (sbQ.size() == 0) begin
            checkOutput("spuriousValid", 32'(resultValid), 32'd0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("result", 32'(result), 32'(e.res));
            checkOutput("resultAddr", 32'(resultAddr), 32'(e.addr));
         end
      end
   end

   task automatic waitReady();
      int n = 0;
      while (!instrReady && n < 8) begin
         step();
         n++;
      end
      if (!instrReady) checkOutput("readyTimeout", 32'd0, 32'd1);
   endtask

   task automatic predict(input logic [15:0] ins, output logic [15:0] a, output logic [15:0] b);
      logic [3:0]  rd, rs;
      logic [15:0] r;
      logic        cmp;
      rd  = ins[11:8];
      rs  = ins[3:0];
      a   = rfModel[rd];
      b   = (ins[15:12] == 4'h0) ? rfModel[rs] : {{8{ins[7]}}, ins[7:0]};
      r   = aluModel(ins, a, b);
      cmp = ((ins[15:12] == 4'h0) && (ins[7:4] == 4'hB)) || (ins[15:12] == 4'hB);
      sbQ.push_back('{res: r, addr: rd});
      if (!cmp) rfModel[rd] = r;
   endtask

   // Entered one cycle after acceptance (READ); leaves the unit back in IDLE.
   task automatic finishOp(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
      checkOutput("readyInRead", 32'(instrReady), 32'd0);
      checkOutput("validInRead", 32'(resultValid), 32'd0);
      step();
      checkOutput("ain", 32'(ain), 32'(a));
      checkOutput("bin", 32'(bin), 32'(b));
      checkOutput("instruction", 32'(instruction), 32'(ins));
      checkOutput("readyInExec", 32'(instrReady), 32'd0);
      step();
      checkOutput("validInWb", 32'(resultValid), 32'd1);
      checkOutput("readyInWb", 32'(instrReady), 32'd0);
      checkOutput("ainHeld", 32'(ain), 32'(a));
      step();
      checkOutput("validAfterWb", 32'(resultValid), 32'd0);
      checkOutput("readyAfterWb", 32'(instrReady), 32'd1);
   endtask

   task automatic applyStimulus(input logic [15:0] ins, input bit doWr, input logic [3:0] wa,
                                input logic [15:0] wd);
      logic [15:0] a, b;
      waitReady();
      if (doWr) begin
         wrEn   = 1'b1;
         wrAddr = wa;
         wrData = wd;
         rfModel[wa] = wd;
      end
      instrIn    = ins;
      instrValid = 1'b1;
      predict(ins, a, b);
      step();
      instrValid = 1'b0;
      wrEn       = 1'b0;
      finishOp(ins, a, b);
   endtask

   task automatic preload(input logic [3:0] wa, input logic [15:0] wd);
      waitReady();
      wrEn   = 1'b1;
      wrAddr = wa;
      wrData = wd;
      rfModel[wa] = wd;
      step();
      wrEn = 1'b0;
   endtask

   // ADDI r,0 exposes RF[r] on Ain and rewrites the same value.
   task automatic readReg(input logic [3:0] r, input logic [15:0] exp, input string tag);
      applyStimulus({4'h5, r, 8'h00}, 1'b0, 4'h0, 16'h0);
      checkOutput(tag, 32'(ain), 32'(exp));
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [15:0] a, b;
      logic [3:0]  opcList [5];
      reset      = 1'b1;
      instrIn    = '0;
      instrValid = 1'b0;
      wrEn       = 1'b0;
      wrAddr     = '0;
      wrData     = '0;
      for (int i = 0; i < 16; i++) rfModel[i] = '0;
      opcList[0] = 4'h0; opcList[1] = 4'h5; opcList[2] = 4'h9;
      opcList[3] = 4'hB; opcList[4] = 4'hD;

      step();
      step();
      reset = 1'b0;
      checkOutput("resetReady", 32'(instrReady), 32'd1);
      checkOutput("resetValid", 32'(resultValid), 32'd0);
      checkOutput("resetAin", 32'(ain), 32'd0);
      checkOutput("resetBin", 32'(bin), 32'd0);
      checkOutput("resetInstr", 32'(instruction), 32'd0);
      checkOutput("resetResult", 32'(result), 32'd0);

      $display("[TB] R-type add");
      preload(4'd1, 16'h0005);
      preload(4'd2, 16'h0003);
      applyStimulus(16'h0152, 1'b0, 4'h0, 16'h0);
      readReg(4'd1, 16'h0008, "rf1AfterAdd");

      $display("[TB] immediate sign extension");
      preload(4'd4, 16'h0010);
      applyStimulus(16'h54FF, 1'b0, 4'h0, 16'h0);
      checkOutput("immBin", 32'(bin), 32'h0000FFFF);
      readReg(4'd4, 16'h000F, "rf4AfterAddi");

      $display("[TB] compares do not write back");
      preload(4'd11, 16'h0042);
      applyStimulus(16'h0BB2, 1'b0, 4'h0, 16'h0);
      readReg(4'd11, 16'h0042, "rf11AfterCmp");
      applyStimulus(16'hB105, 1'b0, 4'h0, 16'h0);
      readReg(4'd1, 16'h0008, "rf1AfterCmpi");

      $display("[TB] Rdest equals Rsrc");
      applyStimulus(16'h0252, 1'b0, 4'h0, 16'h0);
      readReg(4'd2, 16'h0006, "rf2AfterSelfAdd");

      $display("[TB] preload and accept in the same cycle");
      applyStimulus(16'h5600, 1'b1, 4'd6, 16'h0777);
      checkOutput("sameCycleAin", 32'(ain), 32'h0777);

      $display("[TB] busy: held valid and ignored preload");
      waitReady();
      instrIn    = 16'h0152;
      instrValid = 1'b1;
      predict(16'h0152, a, b);
      step();
      instrIn = 16'h5801;
      checkOutput("busyReadyRead", 32'(instrReady), 32'd0);
      step();
      checkOutput("busyReadyExec", 32'(instrReady), 32'd0);
      wrEn   = 1'b1;
      wrAddr = 4'd3;
      wrData = 16'h1234;
      step();
      wrEn = 1'b0;
      checkOutput("busyReadyWb", 32'(instrReady), 32'd0);
      checkOutput("busyValidWb", 32'(resultValid), 32'd1);
      step();
      checkOutput("busyReadyIdle", 32'(instrReady), 32'd1);
      predict(16'h5801, a, b);
      step();
      instrValid = 1'b0;
      finishOp(16'h5801, a, b);
      readReg(4'd3, 16'h0000, "rf3Unchanged");
      readReg(4'd1, 16'h000E, "rf1AfterBusyAdd");

      $display("[TB] random sequence");
      for (int i = 0; i < 10; i++) begin
         logic [15:0] ins;
         ins = {opcList[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), 8'($urandom)};
         if ((i % 3) == 0) begin
            applyStimulus(ins, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom));
         end else begin
            applyStimulus(ins, 1'b0, 4'h0, 16'h0);
         end
      end

      $display("[TB] reset during EXEC");
      preload(4'd10, 16'h0100);
      waitReady();
      instrIn    = 16'h5A33;
      instrValid = 1'b1;
      predict(16'h5A33, a, b);
      step();
      instrValid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      sbQ.delete();
      for (int i = 0; i < 16; i++) rfModel[i] = '0;
      checkOutput("midResetReady", 32'(instrReady), 32'd1);
      checkOutput("midResetValid", 32'(resultValid), 32'd0);
      checkOutput("midResetResult", 32'(result), 32'd0);
      checkOutput("midResetAin", 32'(ain), 32'd0);
      step();
      checkOutput("midResetNoValid1", 32'(resultValid), 32'd0);
      step();
      checkOutput("midResetNoValid2", 32'(resultValid), 32'd0);
      readReg(4'd10, 16'h0000, "rf10AfterReset");

      step();
      checkOutput("queueEmpty", 32'(sbQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
